// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, MDU opcodes and MDU state encoding
package mips_pkg;
    localparam int DATA_32_W = 32;
    localparam int MDU_ITER_DEF = 32;
    typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} mdu_op_t;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;
endpackage

// File: rtl/mips_mdu.sv
// mips_mdu: iterative multiply/divide unit with HI/LO registers
module mips_mdu import mips_pkg::*; #(
    parameter int MDU_ITER = MDU_ITER_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  mdu_op_t              op,
    input  logic [DATA_32_W-1:0] rs_data,
    input  logic [DATA_32_W-1:0] rt_data,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [DATA_32_W-1:0] wdata,
    input  logic                 mf_sel,
    output logic [DATA_32_W-1:0] mf_data,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_32_W-1:0] hi,
    output logic [DATA_32_W-1:0] lo
);
    localparam int W = DATA_32_W;
    localparam int CW = $clog2(MDU_ITER) + 1;

    mdu_state_t state;
    logic [CW-1:0] cnt;
    logic [W-1:0] a;
    logic [2*W-1:0] p;
    logic neg_q, neg_r, dz, is_div;

    logic sgn, rs_neg, rt_neg;
    logic [W-1:0] rs_mag, rt_mag, q_fix, r_fix;
    logic [W:0] mul_sum, div_t, div_sub;
    logic [2*W-1:0] prod_fix;

    assign sgn = (op == OP_MULT) || (op == OP_DIV);
    assign rs_neg = sgn & rs_data[W-1];
    assign rt_neg = sgn & rt_data[W-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;
    // p holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
    assign div_t = {p[2*W-1:W], p[W-1]};
    assign div_sub = div_t - {1'b0, a};
    assign prod_fix = neg_q ? -p : p;
    assign q_fix = dz ? '1 : neg_q ? -p[W-1:0] : p[W-1:0];
    assign r_fix = neg_r ? -p[2*W-1:W] : p[2*W-1:W];
    assign busy = state != IDLE;
    assign mf_data = mf_sel ? hi : lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            a <= '0;
            p <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            is_div <= 1'b0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= op[1] ? DIV : MUL;
                        cnt <= '0;
                        a <= op[1] ? rt_mag : rs_mag;
                        p <= {{W{1'b0}}, op[1] ? rs_mag : rt_mag};
                        neg_q <= rs_neg ^ rt_neg;
                        neg_r <= rs_neg;
                        dz <= op[1] && (rt_data == '0);
                        is_div <= op[1];
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MUL, DIV: begin
                    // a borrow out of the trial subtraction means the divisor did not fit
                    p <= (state == MUL) ? {mul_sum, p[W-1:1]}
                       : {div_sub[W] ? div_t[W-1:0] : div_sub[W-1:0], p[W-2:0], ~div_sub[W]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MDU_ITER - 1)) state <= FIX;
                end
                FIX: begin
                    hi <= is_div ? r_fix : prod_fix[2*W-1:W];
                    lo <= is_div ? q_fix : prod_fix[W-1:0];
                    done <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: randomized and directed checks of mips_mdu against an arithmetic model
module tb_mips_mdu;
    import mips_pkg::*;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, mf_sel = 1'b0;
    mdu_op_t op = OP_MULT;
    logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
    logic [31:0] mf_data, hi, lo;
    logic busy, done;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    mips_mdu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_sel(mf_sel), .mf_data(mf_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // {HI, LO} straight from integer arithmetic
    function automatic logic [63:0] model(mdu_op_t o, logic [31:0] x, logic [31:0] y);
        longint sx, sy;
        int ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = $signed(x);
        iy = $signed(y);
        case (o)
            OP_MULT: return 64'(sx * sy);
            OP_MULTU: return {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (o == OP_DIVU) return {x % y, x / y};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
        endcase
    endfunction

    // disturb: 0 none, 1 start at cycle 5, 2 moves at cycle 5, 3 moves coinciding with start
    task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input int disturb, input string name);
        logic [63:0] e;
        logic [31:0] h0, l0;
        int lat;
        bit hold_ok;
        e = model(o, x, y);
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        op = o;
        rs_data = x;
        rt_data = y;
        start = 1'b1;
        mf_sel = 1'($urandom_range(0, 1));
        if (disturb == 3) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF ^ x; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_at_start: got %b expected 1", name, busy); else passed++;
        lat = 0;
        hold_ok = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (c == 5 && disturb == 1) begin start = 1'b1; op = OP_MULTU; end
            if (c == 5 && disturb == 2) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A5A5A; end
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (done) lat = c;
            else if (hi !== h0 || lo !== l0 || mf_data !== (mf_sel ? h0 : l0) || busy !== 1'b1) hold_ok = 1'b0;
        end
        checks++;
        if (lat != 33) $display("FAIL %s latency: got %0d expected 33", name, lat); else passed++;
        checks++;
        if (!hold_ok) $display("FAIL %s hold: hi/lo/busy changed while busy (got 0 expected 1)", name); else passed++;
        checks++;
        if (hi !== e[63:32]) $display("FAIL %s hi: got %h expected %h", name, hi, e[63:32]); else passed++;
        checks++;
        if (lo !== e[31:0]) $display("FAIL %s lo: got %h expected %h", name, lo, e[31:0]); else passed++;
        checks++;
        if (mf_data !== (mf_sel ? e[63:32] : e[31:0]))
            $display("FAIL %s mf_data: got %h expected %h", name, mf_data, mf_sel ? e[63:32] : e[31:0]);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", name, busy); else passed++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
        else passed++;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", busy, done); else passed++;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || mf_data !== 32'h0)
            $display("FAIL reset_regs: got hi=%h lo=%h mf=%h expected 0", hi, lo, mf_data);
        else passed++;
    endtask

    task automatic test_directed();
        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 0, "mult_7_m3");
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");
        run_op(OP_DIVU, 32'd100, 32'd7, 0, "divu_100_7");
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
        run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, 0, "div_neg_by_zero");
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd100, 32'd0, 1, "divu_by_zero_start_ignored");
        run_op(OP_MULT, 32'h80000000, 32'h80000000, 0, "mult_min_min");
    endtask

    task automatic test_moves();
        @(negedge clk); mthi = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1; mthi = 1'b0; mf_sel = 1'b1; #1;
        checks++;
        if (mf_data !== 32'h12345678) $display("FAIL mthi_mf: got %h expected 12345678", mf_data); else passed++;
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0; mf_sel = 1'b0; #1;
        checks++;
        if (hi !== 32'hCAFEF00D || mf_data !== 32'hCAFEF00D)
            $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected cafef00d", hi, mf_data);
        else passed++;
        run_op(OP_DIVU, 32'd1000, 32'd33, 2, "moves_while_busy");
        run_op(OP_MULT, 32'hFFFF0000, 32'd12345, 3, "start_beats_move");
    endtask

    task automatic test_random();
        mdu_op_t o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = mdu_op_t'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 20));
                2: y = -32'($urandom_range(1, 20));
                default: y = 32'($urandom);
            endcase
            run_op(o, x, y, 0, "random");
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk); op = OP_MULT; rs_data = 32'd99; rt_data = 32'd77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_reset_ctrl: got busy=%b done=%b expected 0 0", busy, done); else passed++;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL mid_reset_regs: got hi=%h lo=%h expected 0 0", hi, lo); else passed++;
        @(negedge clk); rst = 1'b1;
        run_op(OP_DIVU, 32'd9, 32'd3, 0, "divu_after_reset");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 test_reset();
        @(negedge clk); rst = 1'b1;
        test_directed();
        test_back_to_back();
        test_moves();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mips_mdu.md
MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 The block SHALL have the parameter `MDU_ITER`, default 32, giving the number of iteration cycles per operation (one per operand bit).
REQ-002 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port `start`, input, 1 bit: request to begin the operation given by `op`.
REQ-005 The block SHALL have the port `op`, input, `mdu_op_t` (2 bits): MULT, MULTU, DIV or DIVU.
REQ-006 The block SHALL have the port `rs_data`, input, 32 bits: multiplicand or dividend.
REQ-007 The block SHALL have the port `rt_data`, input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have the ports `mthi` and `mtlo`, inputs, 1 bit each: load HI or LO from `wdata`.
REQ-009 The block SHALL have the port `wdata`, input, 32 bits: data for `mthi` and `mtlo`.
REQ-010 The block SHALL have the port `mf_sel`, input, 1 bit: 1 selects HI, 0 selects LO onto `mf_data`.
REQ-011 The block SHALL have the port `mf_data`, output, 32 bits: combinational HI or LO value, the register-file WriteData source for MFHI/MFLO.
REQ-012 The block SHALL have the port `busy`, output, 1 bit: operation in progress; the pipeline stalls MFHI, MFLO, MTHI and MTLO while it is high.
REQ-013 The block SHALL have the port `done`, output, 1 bit: single-cycle pulse, high in the cycle HI and LO first hold a new result.
REQ-014 The block SHALL have the ports `hi` and `lo`, outputs, 32 bits each: architectural HI and LO.

Function
REQ-015 The state machine SHALL have exactly the states IDLE, MUL, DIV and FIX.
REQ-016 In IDLE, `start`=1 at edge E0 SHALL capture operand magnitudes, with signed ops taking the absolute value, plus the result signs, clear the iteration counter, and go to MUL or DIV; `busy` SHALL read 1 from E0.
REQ-017 MUL SHALL perform one shift-add step of a 64-bit product per edge and DIV one restoring shift-subtract step per edge, for `MDU_ITER` edges (E1..E32), then go to FIX.
REQ-018 FIX, at edge E33, SHALL apply sign correction, write HI/LO, set `done`=1 for one cycle, clear `busy` and return to IDLE.
REQ-019 Result latency SHALL be 33 cycles from the start edge.
REQ-020 MULT/MULTU SHALL produce HI = product[63:32] and LO = product[31:0], with two's-complement negation of the 64-bit product when the operand signs differ (MULT only).
REQ-021 DIV/DIVU SHALL produce LO = quotient, truncated toward zero, and HI = remainder; for DIV the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend.
REQ-022 Divide by zero SHALL take full latency and produce LO = 0xFFFFFFFF and HI = `rs_data` unmodified, for both DIV and DIVU.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000 and HI = 0.
REQ-024 `start` while `busy`=1 SHALL be ignored, with no effect on the operation in flight.
REQ-025 `mthi`/`mtlo` in IDLE SHALL write `wdata` to HI/LO at the edge, and both may be asserted in the same cycle.
REQ-026 `mthi`/`mtlo` while `busy`=1 SHALL be ignored.
REQ-027 When `start` and `mthi`/`mtlo` coincide in IDLE, `start` SHALL win and the move SHALL be dropped.
REQ-028 HI and LO SHALL hold their previous values throughout MUL and DIV, changing only in FIX or on an IDLE move.
REQ-029 `mf_data` SHALL reflect the HI/LO register value, never in-flight partials.

Reset
REQ-030 Assertion of `rst` (low) at any time, including mid-operation, SHALL asynchronously force state IDLE, HI = LO = 0, counter = 0, `busy` = 0 and `done` = 0, and SHALL discard the operation in flight.
REQ-031 After deassertion the block SHALL accept `start` at the first rising edge.

Structure
REQ-032 `mdu_op_t` (MULT=0, MULTU=1, DIV=2, DIVU=3), `mdu_state_t` and the `MDU_ITER` default SHALL live in `mips_pkg`; DATA_32_W SHALL be reused for all 32-bit widths.
REQ-033 The block SHALL be a single module with no sub-modules; the sign fixup SHALL be combinational logic inside FIX.

Verification
REQ-034 MULT 7 x 0xFFFFFFFD (-3) -> `done` at cycle 33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7 -> LO = 14, HI = 2.
REQ-037 DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100 after 33 cycles; `start` pulsed at cycle 5 of the operation -> ignored, single `done`.
REQ-038 MTHI 0x12345678 in IDLE, then `mf_sel`=1 -> `mf_data` = 0x12345678; MTLO during `busy` -> LO unchanged.
REQ-039 `rst` low at cycle 10 of MULT -> `busy` = 0, `done` = 0, HI = LO = 0 immediately; a new DIVU 9 / 3 then yields LO = 3, HI = 0.
